// File: rtl/alu_driver_pkg.sv
`default_nettype none
// ============================================================================
// alu_driver_pkg : opcodes, FSM state codes and ALU control type for alu_driver
// Rev 1.0
// ============================================================================
package alu_driver_pkg;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b110;
    localparam logic [2:0] c_op_slt = 3'b111;
    localparam logic [2:0] c_op_nor = 3'b100;

    localparam logic [1:0] c_sel_and = 2'b00;
    localparam logic [1:0] c_sel_or  = 2'b01;
    localparam logic [1:0] c_sel_add = 2'b10;
    localparam logic [1:0] c_sel_slt = 2'b11;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic [1:0] operation;
    } alu_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/alu_driver_if.sv
`default_nettype none
// ============================================================================
// alu_driver_if : command, response and external-ALU bundle for alu_driver
// Rev 1.0
// ============================================================================
interface alu_driver_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_ainv;
    logic             alu_binv;
    logic [1:0]       alu_operation;
    logic [WIDTH-1:0] alu_res;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_zero;
    logic             rsp_err;

    // master: command source, response sink and owner of the external ALU
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_res,
        input  cmd_ready, alu_a, alu_b, alu_ainv, alu_binv, alu_operation,
        input  rsp_valid, rsp_res, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_res,
        output cmd_ready, alu_a, alu_b, alu_ainv, alu_binv, alu_operation,
        output rsp_valid, rsp_res, rsp_zero, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// alu_op_decode : maps a 3-bit opcode to {ainv,binv,operation} plus illegal flag
// Rev 1.0
// ============================================================================
module alu_op_decode
    import alu_driver_pkg::*;
(
    input  logic [2:0] i_op,
    output alu_ctrl_t  o_ctrl,
    output logic       o_illegal
);
    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        case (i_op)
            c_op_and: o_ctrl = '{ainv: 1'b0, binv: 1'b0, operation: c_sel_and};
            c_op_or:  o_ctrl = '{ainv: 1'b0, binv: 1'b0, operation: c_sel_or};
            c_op_add: o_ctrl = '{ainv: 1'b0, binv: 1'b0, operation: c_sel_add};
            c_op_sub: o_ctrl = '{ainv: 1'b0, binv: 1'b1, operation: c_sel_add};
            c_op_slt: o_ctrl = '{ainv: 1'b0, binv: 1'b1, operation: c_sel_slt};
            // NOR via De Morgan: ~a & ~b
            c_op_nor: o_ctrl = '{ainv: 1'b1, binv: 1'b1, operation: c_sel_and};
            default:  o_illegal = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_driver.sv
`default_nettype none
// ============================================================================
// alu_driver : sequences one command at a time through an external
//              combinational ALU and returns the sampled result.
// Rev 1.0
// ============================================================================
module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    alu_driver_if.slave   bus
);
    localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    alu_ctrl_t        r_ctrl;
    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    alu_ctrl_t        w_ctrl;
    logic             w_illegal;
    logic             w_accept;

    alu_op_decode u_decode (
        .i_op      (bus.cmd_op),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    assign bus.cmd_ready = (r_state == c_st_idle) && !reset;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= 4'd0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_ctrl     <= '0;
            r_rsp_res  <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            // ALU inputs keep the last legal command's values
                            r_rsp_res  <= '0;
                            r_rsp_zero <= 1'b1;
                            r_rsp_err  <= 1'b1;
                            r_state    <= c_st_resp;
                        end else begin
                            r_alu_a <= bus.cmd_a;
                            r_alu_b <= bus.cmd_b;
                            r_ctrl  <= w_ctrl;
                            r_cnt   <= 4'd0;
                            r_state <= c_st_exec;
                        end
                    end
                end
                c_st_exec: begin
                    if (r_cnt == c_settle_last) begin
                        r_rsp_res  <= bus.alu_res;
                        r_rsp_zero <= (bus.alu_res == '0);
                        r_rsp_err  <= 1'b0;
                        r_cnt      <= 4'd0;
                        r_state    <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_st_resp: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.alu_a         = r_alu_a;
    assign bus.alu_b         = r_alu_b;
    assign bus.alu_ainv      = r_ctrl.ainv;
    assign bus.alu_binv      = r_ctrl.binv;
    assign bus.alu_operation = r_ctrl.operation;
    assign bus.rsp_valid     = (r_state == c_st_resp);
    assign bus.rsp_res       = r_rsp_res;
    assign bus.rsp_zero      = r_rsp_zero;
    assign bus.rsp_err       = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_alu_driver.sv
`default_nettype none
// ============================================================================
// tb_alu_driver : self-checking bench; provides the external ALU and an
//                 opcode-level reference model.
// Rev 1.0
// ============================================================================
module tb_alu_driver;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst1;
    logic rst4;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] last_a    = '0;
    logic [W-1:0] last_b    = '0;
    logic [3:0]   last_ctrl = '0;

    always #5 clk = ~clk;

    alu_driver_if #(.WIDTH(W)) bus1 ();
    alu_driver_if #(.WIDTH(W)) bus4 ();

    alu_driver #(.WIDTH(W), .SETTLE(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1.slave));
    alu_driver #(.WIDTH(W), .SETTLE(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4.slave));

    // Bit-sliced style ALU with overflow-correct set-less-than
    function automatic logic [W-1:0] ext_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ai, input logic bi, input logic [1:0] sel);
        logic [W-1:0] x, y, s;
        logic         ovf;
        x   = ai ? ~a : a;
        y   = bi ? ~b : b;
        s   = x + y + W'(bi);
        ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        case (sel)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return s;
            default: return W'(s[W-1] ^ ovf);
        endcase
    endfunction

    assign bus1.alu_res = ext_alu(bus1.alu_a, bus1.alu_b, bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation);
    assign bus4.alu_res = ext_alu(bus4.alu_a, bus4.alu_b, bus4.alu_ainv, bus4.alu_binv, bus4.alu_operation);

    // Reference model: what each opcode means arithmetically
    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'b100:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] op);
        return (op != 3'b011) && (op != 3'b101);
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [2:0] op);
        case (op)
            3'b001:  return 4'b0001;
            3'b010:  return 4'b0010;
            3'b110:  return 4'b0110;
            3'b111:  return 4'b0111;
            3'b100:  return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command on bus1 and wait for its response; lat = edges after acceptance
    task automatic send1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        n   = 0;
        bus1.cmd_op    = op;
        bus1.cmd_a     = a;
        bus1.cmd_b     = b;
        bus1.cmd_valid = 1'b1;
        while (!bus1.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus1.cmd_ready) begin
            to = 1'b1;
            bus1.cmd_valid = 1'b0;
            return;
        end
        tick();
        bus1.cmd_valid = 1'b0;
        if (ref_legal(op)) begin
            last_a    = a;
            last_b    = b;
            last_ctrl = ref_ctrl(op);
        end
        while (!bus1.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus1.rsp_valid) to = 1'b1;
    endtask

    task automatic ack1();
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        rst4 = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got %b/%h/%b/%b required 0/0/0/0", bus1.rsp_valid, bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err);
        end
        checks++;
        if ({bus1.alu_a, bus1.alu_b, bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h ctrl=%b%b%b required all 0", bus1.alu_a, bus1.alu_b, bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation);
        end
        checks++;
        if (bus1.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready_low: got %b required 0", bus1.cmd_ready);
        end
        rst1 = 1'b0;
        rst4 = 1'b0;
        #1;
        checks++;
        if ({bus1.cmd_ready, bus4.cmd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_cmd_ready_high: got %b%b required 11", bus1.cmd_ready, bus4.cmd_ready);
        end
    endtask

    task automatic test_directed();
        int lat;
        bit to;
        send1(3'b010, W'(4500), W'(32678), lat, to);
        checks++;
        if (to || lat != 1) begin
            errors++;
            $display("FAIL add_latency: got %0d (timeout %0b) required 1", lat, to);
        end
        checks++;
        if ({bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation} !== 4'b0010) begin
            errors++;
            $display("FAIL add_ctrl: got %b%b%b required 0010", bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation);
        end
        checks++;
        if ({bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err} !== {W'(37178), 2'b00}) begin
            errors++;
            $display("FAIL add_rsp: got %0d/%b/%b required 37178/0/0", bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err);
        end
        ack1();

        send1(3'b110, W'(5), W'(5), lat, to);
        checks++;
        if (to || {bus1.alu_binv, bus1.alu_operation} !== 3'b110 || {bus1.rsp_res, bus1.rsp_zero} !== {W'(0), 1'b1}) begin
            errors++;
            $display("FAIL sub_eq: got binv=%b op=%b res=%h zero=%b to=%b required 1/10/0/1", bus1.alu_binv, bus1.alu_operation, bus1.rsp_res, bus1.rsp_zero, to);
        end
        ack1();

        send1(3'b111, W'(3), W'(7), lat, to);
        checks++;
        if (to || bus1.rsp_res !== W'(1)) begin
            errors++;
            $display("FAIL slt_3_7: got %h required 1", bus1.rsp_res);
        end
        ack1();

        send1(3'b100, W'(0), W'(0), lat, to);
        checks++;
        if (to || {bus1.rsp_res, bus1.rsp_zero} !== {32'hFFFF_FFFF, 1'b0}) begin
            errors++;
            $display("FAIL nor_0_0: got %h zero=%b required ffffffff zero=0", bus1.rsp_res, bus1.rsp_zero);
        end
        ack1();
    endtask

    task automatic test_illegal();
        int lat;
        bit to;
        logic [2:0] ops[2] = '{3'b011, 3'b101};
        send1(3'b001, W'($urandom), W'($urandom), lat, to);
        ack1();
        foreach (ops[i]) begin
            send1(ops[i], W'($urandom), W'($urandom), lat, to);
            checks++;
            if (to || lat != 0 || {bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err} !== {W'(0), 2'b11}) begin
                errors++;
                $display("FAIL illegal_rsp op=%b: got lat=%0d res=%h zero=%b err=%b required 0/0/1/1", ops[i], lat, bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err);
            end
            checks++;
            if ({bus1.alu_a, bus1.alu_b, bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation} !== {last_a, last_b, last_ctrl}) begin
                errors++;
                $display("FAIL illegal_alu_hold op=%b: got %h %h %b%b%b required %h %h %b", ops[i], bus1.alu_a, bus1.alu_b, bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation, last_a, last_b, last_ctrl);
            end
            ack1();
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
            send1(op, a, b, lat, to);
            checks++;
            if (to || lat != (ref_legal(op) ? 1 : 0)) begin
                errors++;
                $display("FAIL rnd_latency op=%b: got %0d (timeout %0b)", op, lat, to);
            end
            checks++;
            if (bus1.rsp_res !== ref_res(op, a, b)) begin
                errors++;
                $display("FAIL rnd_res op=%b a=%h b=%h: got %h required %h", op, a, b, bus1.rsp_res, ref_res(op, a, b));
            end
            checks++;
            if (bus1.rsp_zero !== (ref_res(op, a, b) == '0)) begin
                errors++;
                $display("FAIL rnd_zero op=%b: got %b", op, bus1.rsp_zero);
            end
            checks++;
            if (bus1.rsp_err !== !ref_legal(op)) begin
                errors++;
                $display("FAIL rnd_err op=%b: got %b", op, bus1.rsp_err);
            end
            checks++;
            if ({bus1.alu_a, bus1.alu_b, bus1.alu_ainv, bus1.alu_binv, bus1.alu_operation} !== {last_a, last_b, last_ctrl}) begin
                errors++;
                $display("FAIL rnd_alu op=%b: got %h %h required %h %h ctrl %b", op, bus1.alu_a, bus1.alu_b, last_a, last_b, last_ctrl);
            end
            ack1();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        logic [W-1:0] a, b, na, nb, held;
        a  = W'($urandom);
        b  = W'($urandom);
        na = W'($urandom);
        nb = W'($urandom);
        send1(3'b010, a, b, lat, to);
        held = a + b;
        bus1.cmd_op    = 3'b001;
        bus1.cmd_a     = na;
        bus1.cmd_b     = nb;
        bus1.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (to || {bus1.rsp_valid, bus1.rsp_res, bus1.rsp_zero, bus1.rsp_err, bus1.cmd_ready, bus1.alu_a} !== {1'b1, held, 3'b000, a}) begin
                errors++;
                $display("FAIL stall_hold cyc %0d: got v=%b res=%h rdy=%b alu_a=%h required 1/%h/0/%h", i, bus1.rsp_valid, bus1.rsp_res, bus1.cmd_ready, bus1.alu_a, held, a);
            end
        end
        bus1.rsp_ready = 1'b1;
        tick();
        bus1.rsp_ready = 1'b0;
        checks++;
        if ({bus1.rsp_valid, bus1.cmd_ready, bus1.alu_a} !== {2'b01, a}) begin
            errors++;
            $display("FAIL bubble: got v=%b rdy=%b alu_a=%h required 0/1/%h", bus1.rsp_valid, bus1.cmd_ready, bus1.alu_a, a);
        end
        tick();
        bus1.cmd_valid = 1'b0;
        checks++;
        if ({bus1.rsp_valid, bus1.cmd_ready, bus1.alu_a, bus1.alu_b} !== {2'b00, na, nb}) begin
            errors++;
            $display("FAIL next_accept: got v=%b rdy=%b a=%h b=%h required 0/0/%h/%h", bus1.rsp_valid, bus1.cmd_ready, bus1.alu_a, bus1.alu_b, na, nb);
        end
        tick();
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_res} !== {1'b1, na | nb}) begin
            errors++;
            $display("FAIL next_rsp: got v=%b res=%h required 1/%h", bus1.rsp_valid, bus1.rsp_res, na | nb);
        end
        last_a    = na;
        last_b    = nb;
        last_ctrl = 4'b0001;
        ack1();
    endtask

    task automatic test_settle4_abort();
        int lat;
        int seen;
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        bus4.cmd_op    = 3'b110;
        bus4.cmd_a     = a;
        bus4.cmd_b     = b;
        bus4.cmd_valid = 1'b1;
        checks++;
        if (bus4.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL s4_ready: got %b required 1", bus4.cmd_ready);
        end
        tick();
        bus4.cmd_valid = 1'b0;
        lat = 0;
        while (!bus4.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4 || bus4.rsp_res !== a - b) begin
            errors++;
            $display("FAIL s4_latency_res: got lat=%0d res=%h required 4/%h", lat, bus4.rsp_res, a - b);
        end
        bus4.rsp_ready = 1'b1;
        tick();
        bus4.rsp_ready = 1'b0;

        a = W'($urandom) | W'(1);
        bus4.cmd_op    = 3'b010;
        bus4.cmd_a     = a;
        bus4.cmd_valid = 1'b1;
        tick();
        bus4.cmd_valid = 1'b0;
        checks++;
        if ({bus4.rsp_valid, bus4.alu_a} !== {1'b0, a}) begin
            errors++;
            $display("FAIL s4_exec: got v=%b alu_a=%h required 0/%h", bus4.rsp_valid, bus4.alu_a, a);
        end
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        #1;
        checks++;
        if ({bus4.rsp_valid, bus4.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort_state: got v=%b rdy=%b required 0/1", bus4.rsp_valid, bus4.cmd_ready);
        end
        checks++;
        if ({bus4.alu_a, bus4.alu_b, bus4.alu_ainv, bus4.alu_binv, bus4.alu_operation} !== '0) begin
            errors++;
            $display("FAIL abort_alu: got a=%h b=%h ctrl=%b%b%b required all 0", bus4.alu_a, bus4.alu_b, bus4.alu_ainv, bus4.alu_binv, bus4.alu_operation);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus4.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_rsp: got %0d response cycles required 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1'b1;
        rst4 = 1'b1;
        bus1.cmd_valid = 1'b0;
        bus1.cmd_op    = '0;
        bus1.cmd_a     = '0;
        bus1.cmd_b     = '0;
        bus1.rsp_ready = 1'b0;
        bus4.cmd_valid = 1'b0;
        bus4.cmd_op    = '0;
        bus4.cmd_a     = '0;
        bus4.cmd_b     = '0;
        bus4.rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_back_to_back();
        test_settle4_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width of the external ALU.
REQ-002 SHALL have parameter SETTLE, default 1, range 1..15, the number of cycles the ALU inputs are held before the result is sampled.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: clk input 1, rising-edge clock.
REQ-004 SHALL have reset input 1, synchronous, active-high.
REQ-005 cmd_valid input 1: a command is offered.
REQ-006 cmd_ready output 1: the block can accept a command.
REQ-007 cmd_op input 3: the opcode.
REQ-008 cmd_a, cmd_b input WIDTH: the operands.
REQ-009 alu_a, alu_b output WIDTH: the operands driven to the external ALU.
REQ-010 alu_ainv, alu_binv output 1: the ALU invert controls.
REQ-011 alu_operation output 2: the ALU result select (00 AND, 01 OR, 10 ADD, 11 SLT).
REQ-012 alu_res input WIDTH: the combinational result from the external ALU.
REQ-013 rsp_valid output 1: a response is available; rsp_ready input 1: the consumer accepts it.
REQ-014 rsp_res output WIDTH: the result; rsp_zero output 1: rsp_res equals 0; rsp_err output 1: the opcode was illegal.

Function
REQ-015 Opcode map {ainv,binv,operation} SHALL be:
- 000 AND={0,0,00}
- 001 OR={0,0,01}
- 010 ADD={0,0,10}
- 110 SUB={0,1,10}
- 111 SLT={0,1,11}
- 100 NOR={1,1,00}
- 011, 101: illegal.
REQ-016 FSM states SHALL be IDLE, EXEC and RESP, with a 4-bit settle counter.
REQ-017 cmd_ready SHALL equal (state==IDLE) and not reset; a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-018 On accepting a legal opcode, the block SHALL register cmd_a, cmd_b and the mapped controls onto the alu_* outputs and enter EXEC.
REQ-019 alu_* outputs SHALL be registered and SHALL stay constant from acceptance until the next accepted legal command.
REQ-020 Timing for a legal command accepted at edge T:
- The block SHALL remain in EXEC for exactly SETTLE cycles.
- At edge T+SETTLE it SHALL capture alu_res into rsp_res, set rsp_zero, clear rsp_err, and enter RESP.
REQ-021 On accepting an illegal opcode at edge T, the block SHALL NOT change alu_* and SHALL enter RESP with rsp_res=0, rsp_zero=1, rsp_err=1.
REQ-022 rsp_valid SHALL be 1 exactly in RESP; rsp_res, rsp_zero and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 When rsp_valid and rsp_ready are both 1 at an edge, the block SHALL return to IDLE; the next command can be accepted no earlier than the following edge (one bubble cycle).
REQ-024 cmd_valid SHALL be ignored in EXEC and RESP; no command is queued.
REQ-025 The driver SHALL NOT post-process alu_res; SLT correctness belongs to the external ALU.

Reset
REQ-026 Reset SHALL be synchronous and active-high, and SHALL dominate all other events on the same edge.
REQ-027 After a reset edge: state=IDLE, counter=0, rsp_valid=0, rsp_res=0, rsp_zero=0, rsp_err=0, alu_a=alu_b=0, alu_ainv=alu_binv=0, alu_operation=00.
REQ-028 A reset in EXEC or RESP SHALL discard the operation in progress without producing a response.

Structure
REQ-029 A shared package alu_driver_pkg SHALL hold:
- the opcode constants;
- the state encoding;
- the 4-bit {ainv,binv,operation} control type.
REQ-030 The block SHALL contain one combinational sub-module, alu_op_decode (cmd_op -> ainv, binv, operation, illegal).
REQ-031 The top SHALL instantiate the FSM and registers only; the external ALU is instantiated by the parent and the bench, not by this block.

Verification
REQ-032 ADD, a=4500, b=32678, SETTLE=1, accepted at edge T -> alu controls {0,0,10}; rsp_valid high after edge T+1; rsp_res=37178; rsp_zero=0; rsp_err=0.
REQ-033 SUB, a=5, b=5 -> binv=1, operation=10; rsp_res=0; rsp_zero=1.
REQ-034 SLT, a=3, b=7 -> rsp_res=1; then NOR, a=0, b=0 -> rsp_res=0xFFFFFFFF.
REQ-035 Opcode 011 -> rsp_valid after edge T; rsp_err=1; rsp_res=0; alu_* unchanged from the previous command.
REQ-036 Hold rsp_ready=0 for 5 cycles while cmd_valid=1 with new data -> response stays stable and cmd_ready stays 0; after the handshake, the new command is accepted one cycle later.
REQ-037 SETTLE=4, assert reset in the 2nd EXEC cycle -> after that edge rsp_valid=0, cmd_ready=1, all alu_* outputs 0, and no response is ever issued for the aborted command.
